// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack handshake and holds
// one fetched instruction for the decoder, with branch redirect and in-flight squash.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        nrst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] instruction,
   output logic        instr_valid,
   output logic [31:0] instr_pc,
   output logic        misaligned
);

   typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] addr_q, addr_d;
   logic        drop_q, drop_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic [31:0] ipc_q, ipc_d;
   logic        mis_q, mis_d;
   logic        waiting;

   // A request is outstanding while in REQ without ack; its address must not move.
   assign waiting = (state_q == StReq) && !imem_ack;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      drop_d  = drop_q;
      instr_d = instr_q;
      valid_d = valid_q;
      ipc_d   = ipc_q;
      mis_d   = 1'b0;

      unique case (state_q)
         StIdle: state_d = StReq;
         StReq: begin
            if (imem_ack) begin
               if (drop_q) begin
                  drop_d = 1'b0;
               end else begin
                  instr_d = imem_rdata;
                  ipc_d   = pc_q;
                  valid_d = 1'b1;
                  pc_d    = pc_q + 32'd4;
                  state_d = StHold;
               end
            end
         end
         StHold: begin
            if (valid_q && !stall) begin
               valid_d = 1'b0;
               instr_d = NOP_INSTR;
               state_d = StReq;
            end
         end
         default: state_d = StIdle;
      endcase

      // Redirect overrides ack and stall; a same-cycle ack is simply discarded.
      if (branch_taken) begin
         pc_d    = branch_target & ~32'h3;
         mis_d   = |branch_target[1:0];
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
         ipc_d   = ipc_q;
         state_d = StReq;
         if (waiting) drop_d = 1'b1;
      end

      addr_d = waiting ? addr_q : pc_d;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= StIdle;
         pc_q    <= RESET_PC;
         addr_q  <= RESET_PC;
         drop_q  <= 1'b0;
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
         ipc_q   <= RESET_PC;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         drop_q  <= drop_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         ipc_q   <= ipc_d;
         mis_q   <= mis_d;
      end
   end

   assign imem_req    = (state_q == StReq);
   assign imem_addr   = addr_q;
   assign instruction = instr_q;
   assign instr_valid = valid_q;
   assign instr_pc    = ipc_q;
   assign misaligned  = mis_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a small memory model with programmable wait states
// and a linear sequence of steps with hand-computed expectations.
module tb_instruction_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        nrst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] instruction;
   logic        instr_valid;
   logic [31:0] instr_pc;
   logic        misaligned;

   int n_checks = 0;
   int n_errs   = 0;
   int wait_cycles;
   int wait_cnt;

   instruction_fetch #(
      .RESET_PC (32'h0000_0000),
      .NOP_INSTR(NOP)
   ) dut (
      .clk          (clk),
      .nrst         (nrst),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .instruction  (instruction),
      .instr_valid  (instr_valid),
      .instr_pc     (instr_pc),
      .misaligned   (misaligned)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      case (a)
         32'h0000_0000: mem = 32'h0020_8193;
         32'h0000_0004: mem = 32'h4140_0133;
         32'h0000_0008: mem = 32'h0100_4293;
         default:       mem = ~a;
      endcase
   endfunction

   // Memory acks once the request has been waiting wait_cycles cycles.
   always @(posedge clk or negedge nrst) begin
      if (!nrst) wait_cnt <= 0;
      else if (imem_req && imem_ack) wait_cnt <= 0;
      else if (imem_req) wait_cnt <= wait_cnt + 1;
   end
   assign imem_ack   = imem_req && (wait_cnt >= wait_cycles);
   assign imem_rdata = mem(imem_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      nrst = 1'b0;
      stall = 1'b0;
      branch_taken = 1'b0;
      branch_target = 32'h0;
      wait_cycles = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", imem_req, 1'b0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_instr", instruction, NOP);
      chk("rst_valid", instr_valid, 1'b0);
      chk("rst_pc", instr_pc, 32'h0);
      chk("rst_mis", misaligned, 1'b0);
      nrst = 1'b1;

      // Zero-wait fetches of addr 0 and 4
      step();
      chk("f0_req", imem_req, 1'b1);
      chk("f0_addr", imem_addr, 32'h0);
      chk("f0_valid", instr_valid, 1'b0);
      step();
      chk("f0_hvalid", instr_valid, 1'b1);
      chk("f0_instr", instruction, 32'h0020_8193);
      chk("f0_pc", instr_pc, 32'h0);
      chk("f0_hreq", imem_req, 1'b0);
      step();
      chk("f1_valid", instr_valid, 1'b0);
      chk("f1_req", imem_req, 1'b1);
      chk("f1_addr", imem_addr, 32'h4);
      step();
      chk("f1_hvalid", instr_valid, 1'b1);
      chk("f1_instr", instruction, 32'h4140_0133);
      chk("f1_pc", instr_pc, 32'h4);
      wait_cycles = 4;

      // Four wait states at addr 8; stall asserted ready for the hold phase
      for (int i = 0; i < 5; i++) begin
         step();
         chk("w_req", imem_req, 1'b1);
         chk("w_addr", imem_addr, 32'h8);
         chk("w_valid", instr_valid, 1'b0);
         chk("w_ack", imem_ack, (i == 4));
         if (i == 4) stall = 1'b1;
      end
      wait_cycles = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("s_valid", instr_valid, 1'b1);
         chk("s_instr", instruction, 32'h0100_4293);
         chk("s_pc", instr_pc, 32'h8);
         chk("s_req", imem_req, 1'b0);
      end
      stall = 1'b0;
      step();
      chk("s_rel_valid", instr_valid, 1'b0);
      chk("s_rel_req", imem_req, 1'b1);
      chk("s_rel_addr", imem_addr, 32'hC);
      step();
      chk("c_valid", instr_valid, 1'b1);
      chk("c_pc", instr_pc, 32'hC);

      // Redirect during HOLD, overriding a stall
      stall = 1'b1;
      branch_taken = 1'b1;
      branch_target = 32'h0000_0100;
      step();
      branch_taken = 1'b0;
      stall = 1'b0;
      chk("bh_valid", instr_valid, 1'b0);
      chk("bh_instr", instruction, NOP);
      chk("bh_mis", misaligned, 1'b0);
      chk("bh_addr", imem_addr, 32'h100);
      chk("bh_pc", instr_pc, 32'hC);
      step();
      chk("bh_hpc", instr_pc, 32'h100);
      chk("bh_hinstr", instruction, ~32'h100);

      // Redirect to a misaligned target while a request to 0x10 is outstanding
      branch_taken = 1'b1;
      branch_target = 32'h0000_0010;
      wait_cycles = 2;
      step();
      branch_taken = 1'b0;
      chk("br_addr0", imem_addr, 32'h10);
      chk("br_ack0", imem_ack, 1'b0);
      branch_taken = 1'b1;
      branch_target = 32'h0000_0202;
      step();
      branch_taken = 1'b0;
      chk("br_addr1", imem_addr, 32'h10);
      chk("br_mis1", misaligned, 1'b1);
      chk("br_valid1", instr_valid, 1'b0);
      step();
      chk("br_addr2", imem_addr, 32'h10);
      chk("br_ack2", imem_ack, 1'b1);
      chk("br_mis2", misaligned, 1'b0);
      step();
      chk("br_valid3", instr_valid, 1'b0);
      chk("br_req3", imem_req, 1'b1);
      chk("br_addr3", imem_addr, 32'h200);
      wait_cycles = 0;
      step();
      chk("br_valid4", instr_valid, 1'b1);
      chk("br_pc4", instr_pc, 32'h200);
      chk("br_instr4", instruction, ~32'h200);

      // Reset while a request to 0x40 is pending
      branch_taken = 1'b1;
      branch_target = 32'h0000_0040;
      wait_cycles = 5;
      step();
      branch_taken = 1'b0;
      chk("ra_req", imem_req, 1'b1);
      chk("ra_addr", imem_addr, 32'h40);
      #2 nrst = 1'b0;
      #1;
      chk("ra_rreq", imem_req, 1'b0);
      chk("ra_raddr", imem_addr, 32'h0);
      chk("ra_rinstr", instruction, NOP);
      chk("ra_rvalid", instr_valid, 1'b0);
      chk("ra_rpc", instr_pc, 32'h0);
      chk("ra_rmis", misaligned, 1'b0);
      wait_cycles = 0;
      #1 nrst = 1'b1;
      step();
      chk("rr_req", imem_req, 1'b1);
      chk("rr_addr", imem_addr, 32'h0);
      step();
      chk("rr_pc", instr_pc, 32'h0);
      chk("rr_instr", instruction, 32'h0020_8193);

      // PC wrap from FFFF_FFFC to 0
      branch_taken = 1'b1;
      branch_target = 32'hFFFF_FFFC;
      step();
      branch_taken = 1'b0;
      chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
      step();
      chk("wr_pc", instr_pc, 32'hFFFF_FFFC);
      chk("wr_valid", instr_valid, 1'b1);
      step();
      chk("wr_naddr", imem_addr, 32'h0);
      chk("wr_nreq", imem_req, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
